// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'd0;
   localparam logic [3:0] OP_OR  = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;

   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_V = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_N = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per multiply.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic                busy;
   logic [CW-1:0]       count;
   logic [2*WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]    mplier;

   // done is a one-cycle pulse after the final step; the product stays in prod until the next start
   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         done   <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         done   <= 1'b0;
         count  <= CW'(WIDTH);
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         prod   <= '0;
      end else if (busy && !done) begin
         prod   <= prod + (mplier[0] ? mcand : '0);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
         if (count == CW'(1)) done <= 1'b1;
      end else if (done) begin
         busy <= 1'b0;
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops inline, MUL via the iterative multiplier.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [3:0]        sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out,
   output logic [3:0]        flags,
   output logic              err
);

   state_t              state, state_nx;
   logic                out_valid_nx, err_nx;
   logic [WIDTH-1:0]    out_nx;
   logic [3:0]          flags_nx;

   logic [WIDTH-1:0]    res_c;
   logic [3:0]          flg_c;
   logic                err_c, carry_c, ovf_c;
   logic [SHW-1:0]      shamt;

   logic                accept, mul_start, mul_done;
   logic [2*WIDTH-1:0]  mul_prod;
   logic [WIDTH-1:0]    mul_lo, mul_hi;

   assign shamt     = b[SHW-1:0];
   assign in_ready  = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (sel == OP_MUL);
   assign mul_lo    = mul_prod[WIDTH-1:0];
   assign mul_hi    = mul_prod[2*WIDTH-1:WIDTH];

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   // Single-cycle datapath; illegal opcodes force a zero result with all flags clear
   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      err_c   = 1'b0;
      case (sel)
         OP_AND: res_c = a & b;
         OP_OR:  res_c = a | b;
         OP_XOR: res_c = a ^ b;
         OP_ADD: begin
            {carry_c, res_c} = {1'b0, a} + {1'b0, b};
            ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_c   = a - b;
            carry_c = (a < b);
            ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: res_c = WIDTH'($signed(a) < $signed(b));
         OP_SLL: res_c = a << shamt;
         OP_SRL: res_c = a >> shamt;
         OP_SRA: res_c = $unsigned($signed(a) >>> shamt);
         OP_MUL: res_c = '0;
         default: err_c = 1'b1;
      endcase
      flg_c = '0;
      if (!err_c) begin
         flg_c[FLAG_C] = carry_c;
         flg_c[FLAG_V] = ovf_c;
         flg_c[FLAG_Z] = (res_c == '0);
         flg_c[FLAG_N] = res_c[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         flags     <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         out_valid <= out_valid_nx;
         out       <= out_nx;
         flags     <= flags_nx;
         err       <= err_nx;
      end
   end

   // Next state and result register update; result held until consumed
   always_comb begin
      state_nx     = state;
      out_valid_nx = out_valid;
      out_nx       = out;
      flags_nx     = flags;
      err_nx       = err;
      if (out_valid && out_ready) out_valid_nx = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (sel == OP_MUL) begin
                  state_nx = ST_MUL;
               end else begin
                  out_valid_nx = 1'b1;
                  out_nx       = res_c;
                  flags_nx     = flg_c;
                  err_nx       = err_c;
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_nx         = ST_IDLE;
               out_valid_nx     = 1'b1;
               out_nx           = mul_lo;
               flags_nx         = '0;
               flags_nx[FLAG_V] = (mul_hi != '0);
               flags_nx[FLAG_Z] = (mul_lo == '0);
               flags_nx[FLAG_N] = mul_lo[WIDTH-1];
               err_nx           = 1'b0;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=32 with hand-written multi-cycle sequences.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic        in_ready, out_valid, err;
   logic [31:0] a, b, out;
   logic [3:0]  sel, flags;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flags     (flags),
      .err       (err)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] res;
      logic [3:0]  flg;   // {carry, overflow, zero, negative}
      logic        e;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one latency-1 op with out_ready=1 and check the registered result
   task automatic apply(input string name, input logic [3:0] op, input logic [31:0] va, vb,
                        input logic [31:0] res, input logic [3:0] flg, input logic e);
      sel = op; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
      chk({name, " in_ready"}, 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      chk({name, " out_valid"}, 64'(out_valid), 64'(1));
      chk({name, " out"}, 64'(out), 64'(res));
      chk({name, " flags"}, 64'(flags), 64'(flg));
      chk({name, " err"}, 64'(err), 64'(e));
   endtask

   task automatic do_mul(input logic [31:0] va, vb, res, input logic [3:0] flg);
      int  n;
      logic rdy_seen;
      sel = OP_MUL; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
      chk("mul in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      n = 0;
      rdy_seen = 1'b0;
      while (!out_valid && n < 100) begin
         if (in_ready) rdy_seen = 1'b1;
         tick();
         n++;
      end
      chk("mul latency", 64'(n), 64'(33));
      chk("mul in_ready busy", 64'(rdy_seen), 64'(0));
      chk("mul out", 64'(out), 64'(res));
      chk("mul flags", 64'(flags), 64'(flg));
      chk("mul err", 64'(err), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  n;
      logic seen;

      vecs[0]  = '{OP_AND, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 4'b0000, 1'b0};
      vecs[1]  = '{OP_OR,  32'h00000000, 32'h00000000, 32'h00000000, 4'b0010, 1'b0};
      vecs[2]  = '{OP_XOR, 32'h80000000, 32'h00000001, 32'h80000001, 4'b0001, 1'b0};
      vecs[3]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1'b0};
      vecs[4]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1'b0};
      vecs[5]  = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0100, 1'b0};
      vecs[6]  = '{OP_SUB, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b1001, 1'b0};
      vecs[7]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4'b0000, 1'b0};
      vecs[8]  = '{OP_SLT, 32'h00000005, 32'h00000003, 32'h00000000, 4'b0010, 1'b0};
      vecs[9]  = '{OP_SLL, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000, 1'b0};
      vecs[10] = '{OP_SLL, 32'h12345678, 32'h00000000, 32'h12345678, 4'b0000, 1'b0};
      vecs[11] = '{OP_SRL, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1'b0};
      vecs[12] = '{OP_SRA, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b0001, 1'b0};
      vecs[13] = '{4'd12,  32'h12345678, 32'h00000001, 32'h00000000, 4'b0000, 1'b1};
      vecs[14] = '{4'd15,  32'h00000001, 32'h00000001, 32'h00000000, 4'b0000, 1'b1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
      repeat (3) tick();
      chk("reset in_ready", 64'(in_ready), 64'(0));
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset out", 64'(out), 64'(0));
      chk("reset flags", 64'(flags), 64'(0));
      chk("reset err", 64'(err), 64'(0));
      rst = 1'b0;
      #1;
      chk("post-reset in_ready", 64'(in_ready), 64'(1));

      for (int i = 0; i < 15; i++)
         apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].va, vecs[i].vb,
               vecs[i].res, vecs[i].flg, vecs[i].e);

      do_mul(32'h00010000, 32'h00010000, 32'h00000000, 4'b0110);
      do_mul(32'h00000003, 32'h00000005, 32'h0000000F, 4'b0000);
      do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0100);

      // Back-to-back logic ops, one result per cycle
      out_ready = 1'b1; in_valid = 1'b1; a = 32'h000000F0; b = 32'h0000003C;
      sel = OP_AND; tick();
      chk("b2b and out", 64'(out), 64'h30);
      chk("b2b and valid", 64'(out_valid), 64'(1));
      sel = OP_OR; tick();
      chk("b2b or out", 64'(out), 64'hFC);
      chk("b2b or valid", 64'(out_valid), 64'(1));
      sel = OP_XOR; tick();
      chk("b2b xor out", 64'(out), 64'hCC);
      chk("b2b xor valid", 64'(out_valid), 64'(1));

      // Stall: result must hold while the consumer is not ready
      out_ready = 1'b0; sel = OP_ADD; a = 32'd1; b = 32'd1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d in_ready", k), 64'(in_ready), 64'(0));
         tick();
         chk($sformatf("stall%0d out", k), 64'(out), 64'hCC);
         chk($sformatf("stall%0d valid", k), 64'(out_valid), 64'(1));
      end
      out_ready = 1'b1;
      #1;
      chk("release in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      chk("release out", 64'(out), 64'h2);
      chk("release valid", 64'(out_valid), 64'(1));
      tick();
      chk("drain valid", 64'(out_valid), 64'(0));

      // Reset in the middle of a multiply
      sel = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid-mul rst valid", 64'(out_valid), 64'(0));
      seen = 1'b0;
      n = 0;
      while (n < 40) begin
         if (out_valid) seen = 1'b1;
         tick();
         n++;
      end
      chk("aborted mul result", 64'(seen), 64'(0));
      apply("post-rst add", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width; it is derived, not overridden.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the offered operation this cycle.
REQ-007 The block SHALL have port a, input, WIDTH, meaning the first operand.
REQ-008 The block SHALL have port b, input, WIDTH, meaning the second operand or shift amount (b[SHW-1:0]).
REQ-009 The block SHALL have port sel, input, 4, meaning the opcode.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the result is held.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-012 The block SHALL have port out, output, WIDTH, meaning the result.
REQ-013 The block SHALL have port flags, output, 4, meaning {carry, overflow, zero, negative} for the result.
REQ-014 The block SHALL have port err, output, 1, meaning an illegal opcode was executed.

Function
REQ-015 Opcodes SHALL be: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL, 8 SRA, 9 MUL (low WIDTH bits of the unsigned product), and 10-15 illegal.
REQ-016 An operation SHALL be accepted on a cycle with in_valid && in_ready; operands are captured on that edge.
REQ-017 in_ready SHALL be 1 iff the FSM is IDLE and (!out_valid || out_ready), giving one-result-per-cycle throughput for non-MUL ops.
REQ-018 For ops 0-8 and illegal ops, out/flags/err SHALL be registered so that out_valid rises on the edge after acceptance (latency 1).
REQ-019 For MUL, the FSM SHALL go IDLE->MUL, iterate one shift-add step per cycle for WIDTH cycles, then load the result and return to IDLE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-020 FSM states SHALL be IDLE and MUL only; in_ready SHALL be 0 throughout MUL.
REQ-021 out, flags, and err SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid SHALL clear on the edge where out_ready is high, unless a new op is accepted on the same edge (then out_valid stays 1 with the new result).
REQ-023 carry SHALL be the bit WIDTH carry-out for ADD, the borrow (a<b unsigned) for SUB, and 0 otherwise.
REQ-024 overflow SHALL be signed two's-complement overflow for ADD/SUB, and 1 for MUL when the upper WIDTH product bits are nonzero; it is 0 otherwise.
REQ-025 zero SHALL be (out==0), and negative SHALL be out[WIDTH-1], for every op.
REQ-026 For shifts, only b[SHW-1:0] SHALL be used; a shift amount of 0 returns a unchanged.
REQ-027 An illegal opcode SHALL produce out=0, flags=0, and err=1 with latency 1; err is 0 for legal ops.
REQ-028 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL force the FSM to IDLE, out_valid=0, out=0, flags=0, err=0, and clear the multiplier state; in_ready is 0 during reset.
REQ-030 Reset asserted during MUL SHALL abort the multiply with no result produced; the first op after rst deasserts is accepted normally.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode localparams, the flag bit indices, and the FSM state enum.
REQ-032 The iterative multiplier SHALL be sub-module alu_mul_seq (start/done handshake, WIDTH parameter); all other ops are inline.

Verification
REQ-033 The bench SHALL cover this scenario: WIDTH=32, ADD a=FFFFFFFF b=1 -> out=0, carry=1, zero=1, overflow=0, valid after 1 cycle.
REQ-034 The bench SHALL cover this scenario: SUB a=80000000 b=1 -> out=7FFFFFFF, overflow=1, carry=0; SLT a=FFFFFFFF b=0 -> out=1.
REQ-035 The bench SHALL cover this scenario: MUL a=00010000 b=00010000 -> out=0, overflow=1, out_valid exactly 33 cycles after acceptance, and in_ready=0 meanwhile.
REQ-036 The bench SHALL cover this scenario: back-to-back AND/OR/XOR with out_ready=1 -> one result per cycle; with out_ready held 0 for 3 cycles -> in_ready=0 and out stable.
REQ-037 The bench SHALL cover this scenario: sel=12 -> err=1, out=0; SRA a=80000000 b=0000001F -> FFFFFFFF; SLL by b=0x21 -> shift of 1.
REQ-038 The bench SHALL cover this scenario: rst pulsed mid-MUL -> out_valid=0 next cycle, no result emitted, and a following ADD 2+3 returns 5.
